// File: rtl/shape_pkg.sv
// Shared types and defaults for the shape drawer pixel generator.
//   shape_mode_e  : command kind (Bresenham line or filled rectangle)
//   shape_state_e : control FSM states
//   SCREEN_X_MAX / SCREEN_Y_MAX : default visible screen limits (640x480)
package shape_pkg;

    typedef enum logic {
        LINE = 1'b0,
        RECT = 1'b1
    } shape_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } shape_state_e;

    localparam int unsigned SCREEN_X_MAX = 639;
    localparam int unsigned SCREEN_Y_MAX = 479;

endpackage

// File: rtl/line_stepper.sv
// Combinational Bresenham step: given the current point and error term,
// produce the next point and error term. Works in all octants.
// Ports:
//   i_x, i_y         current point
//   i_err            current error term (signed)
//   i_dx             |x1-x0| (non-negative, signed)
//   i_dy             -|y1-y0| (non-positive, signed)
//   i_sx_neg/sy_neg  1 = step toward smaller coordinate
//   o_x, o_y, o_err  next point and error term
module line_stepper #(
    parameter int COORD_W = 11
) (
    input  logic                      [COORD_W-1:0] i_x,
    input  logic                      [COORD_W-1:0] i_y,
    input  logic signed               [COORD_W+1:0] i_err,
    input  logic signed               [COORD_W+1:0] i_dx,
    input  logic signed               [COORD_W+1:0] i_dy,
    input  logic                                    i_sx_neg,
    input  logic                                    i_sy_neg,
    output logic                      [COORD_W-1:0] o_x,
    output logic                      [COORD_W-1:0] o_y,
    output logic signed               [COORD_W+1:0] o_err
);

    logic signed [COORD_W+2:0] w_e2;
    logic signed [COORD_W+2:0] w_dx_ext;
    logic signed [COORD_W+2:0] w_dy_ext;
    logic                      w_step_x;
    logic                      w_step_y;
    logic signed [COORD_W+1:0] w_add_x;
    logic signed [COORD_W+1:0] w_add_y;

    // e2 = 2*err carries one extra bit so the doubling never overflows
    assign w_e2     = {i_err, 1'b0};
    assign w_dx_ext = {i_dx[COORD_W+1], i_dx};
    assign w_dy_ext = {i_dy[COORD_W+1], i_dy};

    assign w_step_x = (w_e2 >= w_dy_ext);
    assign w_step_y = (w_e2 <= w_dx_ext);

    assign w_add_x = w_step_x ? i_dy : '0;
    assign w_add_y = w_step_y ? i_dx : '0;
    assign o_err   = i_err + w_add_x + w_add_y;

    assign o_x = w_step_x ? (i_x + (i_sx_neg ? {COORD_W{1'b1}} : COORD_W'(1))) : i_x;
    assign o_y = w_step_y ? (i_y + (i_sy_neg ? {COORD_W{1'b1}} : COORD_W'(1))) : i_y;

endmodule

// File: rtl/shape_drawer.sv
// Pixel generator for the framebuffer write path. Accepts a line or filled
// rectangle command and streams one coordinate/colour per handshake,
// skipping off-screen points without emitting them.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, ready          command handshake (accepted when both high)
//   mode                  0 = line, 1 = filled rectangle
//   x0, y0, x1, y1        endpoints (line) or opposite corners (rectangle)
//   color_in              colour for the whole command
//   px_valid, px_ready    pixel output handshake
//   px_x, px_y, px_color  pixel coordinate and colour
//   done                  one-cycle pulse after the last point of a command
module shape_drawer
    import shape_pkg::*;
#(
    parameter int          COORD_W = 11,
    parameter int          COLOR_W = 1,
    parameter int unsigned X_MAX   = SCREEN_X_MAX,
    parameter int unsigned Y_MAX   = SCREEN_Y_MAX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] color_in,
    output logic               ready,
    output logic               px_valid,
    input  logic               px_ready,
    output logic [COORD_W-1:0] px_x,
    output logic [COORD_W-1:0] px_y,
    output logic [COLOR_W-1:0] px_color,
    output logic               done
);

    localparam logic [COORD_W-1:0] LP_X_MAX = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] LP_Y_MAX = COORD_W'(Y_MAX);

    shape_state_e              r_state;
    shape_state_e              w_next_state;

    // Captured command. For rectangles SETUP rewrites these in place as
    // (xl, yl, xh, yh) so the end test is the same for both modes.
    shape_mode_e               r_mode;
    logic        [COORD_W-1:0] r_x0;
    logic        [COORD_W-1:0] r_y0;
    logic        [COORD_W-1:0] r_x1;
    logic        [COORD_W-1:0] r_y1;

    // Current point and line stepping state
    logic        [COORD_W-1:0] r_x;
    logic        [COORD_W-1:0] r_y;
    logic        [COLOR_W-1:0] r_color;
    logic signed [COORD_W+1:0] r_err;
    logic signed [COORD_W+1:0] r_dx;
    logic signed [COORD_W+1:0] r_dy;
    logic                      r_sx_neg;
    logic                      r_sy_neg;

    logic        [COORD_W-1:0] w_adx;
    logic        [COORD_W-1:0] w_ady;
    logic        [COORD_W-1:0] w_ln_x;
    logic        [COORD_W-1:0] w_ln_y;
    logic signed [COORD_W+1:0] w_ln_err;
    logic                      w_clip;
    logic                      w_last;
    logic                      w_advance;

    assign w_adx = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    assign w_ady = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);

    assign w_clip    = (r_x > LP_X_MAX) || (r_y > LP_Y_MAX);
    assign w_last    = (r_x == r_x1) && (r_y == r_y1);
    // Clipped points advance unconditionally; visible ones wait for px_ready
    assign w_advance = (r_state == RUN) && (w_clip || px_ready);

    line_stepper #(
        .COORD_W (COORD_W)
    ) u_line_stepper (
        .i_x      (r_x),
        .i_y      (r_y),
        .i_err    (r_err),
        .i_dx     (r_dx),
        .i_dy     (r_dy),
        .i_sx_neg (r_sx_neg),
        .i_sy_neg (r_sy_neg),
        .o_x      (w_ln_x),
        .o_y      (w_ln_y),
        .o_err    (w_ln_err)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        px_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_next_state = SETUP;
                end
            end
            SETUP: begin
                w_next_state = RUN;
            end
            RUN: begin
                px_valid = !w_clip;
                if (w_advance && w_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Command capture, rectangle normalisation and line parameters
    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) begin
            r_mode <= shape_mode_e'(mode);
            r_x0   <= x0;
            r_y0   <= y0;
            r_x1   <= x1;
            r_y1   <= y1;
        end else if (r_state == SETUP) begin
            if (r_mode == RECT) begin
                r_x0 <= (r_x0 <= r_x1) ? r_x0 : r_x1;
                r_x1 <= (r_x0 <= r_x1) ? r_x1 : r_x0;
                r_y0 <= (r_y0 <= r_y1) ? r_y0 : r_y1;
                r_y1 <= (r_y0 <= r_y1) ? r_y1 : r_y0;
            end
            r_dx     <= $signed({2'b00, w_adx});
            r_dy     <= -$signed({2'b00, w_ady});
            r_err    <= $signed({2'b00, w_adx}) - $signed({2'b00, w_ady});
            r_sx_neg <= (r_x1 < r_x0);
            r_sy_neg <= (r_y1 < r_y0);
        end else if (w_advance && !w_last && r_mode == LINE) begin
            r_err <= w_ln_err;
        end
    end

    // Current point: these drive the pixel outputs, so they are reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_color <= color_in;
                    end
                end
                SETUP: begin
                    if (r_mode == RECT) begin
                        r_x <= (r_x0 <= r_x1) ? r_x0 : r_x1;
                        r_y <= (r_y0 <= r_y1) ? r_y0 : r_y1;
                    end else begin
                        r_x <= r_x0;
                        r_y <= r_y0;
                    end
                end
                RUN: begin
                    if (w_advance && !w_last) begin
                        if (r_mode == LINE) begin
                            r_x <= w_ln_x;
                            r_y <= w_ln_y;
                        end else if (r_x == r_x1) begin
                            // end of a raster row: wrap to xl on the next row
                            r_x <= r_x0;
                            r_y <= r_y + COORD_W'(1);
                        end else begin
                            r_x <= r_x + COORD_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign px_x     = r_x;
    assign px_y     = r_y;
    assign px_color = r_color;

endmodule

// File: tb/tb_shape_drawer.sv
module tb_shape_drawer;

    localparam int CW = 11;
    localparam int KW = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          mode;
    logic [CW-1:0] x0;
    logic [CW-1:0] y0;
    logic [CW-1:0] x1;
    logic [CW-1:0] y1;
    logic [KW-1:0] color_in;
    logic          ready;
    logic          px_valid;
    logic          px_ready;
    logic [CW-1:0] px_x;
    logic [CW-1:0] px_y;
    logic [KW-1:0] px_color;
    logic          done;

    always #5 clk = ~clk;

    shape_drawer #(
        .COORD_W (CW),
        .COLOR_W (KW),
        .X_MAX   (639),
        .Y_MAX   (479)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .x0       (x0),
        .y0       (y0),
        .x1       (x1),
        .y1       (y1),
        .color_in (color_in),
        .ready    (ready),
        .px_valid (px_valid),
        .px_ready (px_ready),
        .px_x     (px_x),
        .px_y     (px_y),
        .px_color (px_color),
        .done     (done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int q_x[$];
    int q_y[$];
    int q_c[$];
    int first_valid_cyc;
    int last_xfer_cyc;
    int done_cyc;
    int start_cyc;
    int stall_viol;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_cmd(input logic m, input int ax0, input int ay0,
                            input int ax1, input int ay1, input logic c);
        mode     = m;
        x0       = CW'(ax0);
        y0       = CW'(ay0);
        x1       = CW'(ax1);
        y1       = CW'(ay1);
        color_in = c;
        start    = 1'b1;
        tick();
        start     = 1'b0;
        start_cyc = cyc;
    endtask

    // Records every transferred pixel until done, optionally toggling
    // px_ready 1,0,0,1 and noting any output change during a stall.
    task automatic collect(input bit toggle, input int budget);
        bit            pat [4];
        logic          pv_prev;
        logic          pr_prev;
        logic [CW-1:0] x_prev;
        logic [CW-1:0] y_prev;
        logic [KW-1:0] c_prev;
        pat     = '{1'b1, 1'b0, 1'b0, 1'b1};
        pv_prev = 1'b0;
        pr_prev = 1'b0;
        x_prev  = '0;
        y_prev  = '0;
        c_prev  = '0;
        q_x.delete();
        q_y.delete();
        q_c.delete();
        first_valid_cyc = -1;
        last_xfer_cyc   = -1;
        done_cyc        = -1;
        stall_viol      = 0;
        for (int i = 0; i < budget; i++) begin
            px_ready = toggle ? pat[i % 4] : 1'b1;
            if (pv_prev && !pr_prev &&
                (px_valid !== 1'b1 || px_x !== x_prev || px_y !== y_prev || px_color !== c_prev))
                stall_viol++;
            if (px_valid === 1'b1) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (px_ready) begin
                    q_x.push_back(int'(px_x));
                    q_y.push_back(int'(px_y));
                    q_c.push_back(int'(px_color));
                    last_xfer_cyc = cyc;
                end
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            pv_prev = px_valid;
            pr_prev = px_ready;
            x_prev  = px_x;
            y_prev  = px_y;
            c_prev  = px_color;
            tick();
        end
        px_ready = 1'b1;
        if (done_cyc < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL collect_timeout: done not seen within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        start    = 1'b0;
        mode     = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        color_in = '0;
        px_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (px_valid !== 1'b0) begin n_bad++; $display("FAIL reset_px_valid: got %b want 0", px_valid); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (px_x !== CW'(0)) begin n_bad++; $display("FAIL reset_px_x: got %0d want 0", px_x); end
        n_cmp++; if (px_y !== CW'(0)) begin n_bad++; $display("FAIL reset_px_y: got %0d want 0", px_y); end
        n_cmp++; if (px_color !== KW'(0)) begin n_bad++; $display("FAIL reset_px_color: got %0d want 0", px_color); end
    endtask

    task automatic test_hline();
        px_ready = 1'b1;
        send_cmd(1'b0, 0, 0, 5, 0, 1'b1);
        collect(1'b0, 100);
        n_cmp++; if (q_x.size() !== 6) begin n_bad++; $display("FAIL hline_count: got %0d want 6", q_x.size()); end
        for (int i = 0; i < q_x.size() && i < 6; i++) begin
            n_cmp++;
            if (q_x[i] !== i || q_y[i] !== 0 || q_c[i] !== 1) begin
                n_bad++;
                $display("FAIL hline_px%0d: got (%0d,%0d,c%0d) want (%0d,0,c1)", i, q_x[i], q_y[i], q_c[i], i);
            end
        end
        n_cmp++; if (first_valid_cyc !== start_cyc + 1) begin n_bad++; $display("FAIL hline_latency: got cycle %0d want %0d", first_valid_cyc, start_cyc + 1); end
        n_cmp++; if (done_cyc !== last_xfer_cyc + 1) begin n_bad++; $display("FAIL hline_done_timing: got cycle %0d want %0d", done_cyc, last_xfer_cyc + 1); end
        tick();
        n_cmp++; if (ready !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL hline_ready_after_done: got ready=%b done=%b want 1/0", ready, done); end
    endtask

    task automatic test_steep();
        int ex[8];
        int ey[8];
        ex = '{3, 3, 2, 2, 1, 1, 0, 0};
        ey = '{7, 6, 5, 4, 3, 2, 1, 0};
        send_cmd(1'b0, 3, 7, 0, 0, 1'b0);
        collect(1'b0, 100);
        n_cmp++; if (q_x.size() !== 8) begin n_bad++; $display("FAIL steep_count: got %0d want 8", q_x.size()); end
        for (int i = 0; i < q_x.size() && i < 8; i++) begin
            n_cmp++;
            if (q_x[i] !== ex[i] || q_y[i] !== ey[i]) begin
                n_bad++;
                $display("FAIL steep_px%0d: got (%0d,%0d) want (%0d,%0d)", i, q_x[i], q_y[i], ex[i], ey[i]);
            end
        end
        tick();
    endtask

    task automatic test_rect();
        int idx;
        send_cmd(1'b1, 2, 3, 0, 1, 1'b1);
        collect(1'b0, 100);
        n_cmp++; if (q_x.size() !== 9) begin n_bad++; $display("FAIL rect_count: got %0d want 9", q_x.size()); end
        idx = 0;
        for (int yy = 1; yy <= 3; yy++) begin
            for (int xx = 0; xx <= 2; xx++) begin
                if (idx < q_x.size()) begin
                    n_cmp++;
                    if (q_x[idx] !== xx || q_y[idx] !== yy || q_c[idx] !== 1) begin
                        n_bad++;
                        $display("FAIL rect_px%0d: got (%0d,%0d,c%0d) want (%0d,%0d,c1)", idx, q_x[idx], q_y[idx], q_c[idx], xx, yy);
                    end
                end
                idx++;
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        px_ready = 1'b1;
        send_cmd(1'b0, 0, 0, 5, 0, 1'b0);
        collect(1'b1, 200);
        n_cmp++; if (q_x.size() !== 6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", q_x.size()); end
        for (int i = 0; i < q_x.size() && i < 6; i++) begin
            n_cmp++;
            if (q_x[i] !== i || q_y[i] !== 0) begin
                n_bad++;
                $display("FAIL bp_px%0d: got (%0d,%0d) want (%0d,0)", i, q_x[i], q_y[i], i);
            end
        end
        n_cmp++; if (stall_viol !== 0) begin n_bad++; $display("FAIL bp_stall_stable: got %0d changes want 0", stall_viol); end
        tick();
    endtask

    task automatic test_clip();
        send_cmd(1'b0, 636, 479, 642, 479, 1'b1);
        collect(1'b0, 100);
        n_cmp++; if (q_x.size() !== 4) begin n_bad++; $display("FAIL clip_count: got %0d want 4", q_x.size()); end
        for (int i = 0; i < q_x.size() && i < 4; i++) begin
            n_cmp++;
            if (q_x[i] !== 636 + i || q_y[i] !== 479) begin
                n_bad++;
                $display("FAIL clip_px%0d: got (%0d,%0d) want (%0d,479)", i, q_x[i], q_y[i], 636 + i);
            end
        end
        // three skipped points take one cycle each, then the DONE cycle
        n_cmp++; if (done_cyc !== last_xfer_cyc + 4) begin n_bad++; $display("FAIL clip_done_timing: got cycle %0d want %0d", done_cyc, last_xfer_cyc + 4); end
        tick();
    endtask

    task automatic test_abort();
        px_ready = 1'b1;
        send_cmd(1'b0, 0, 0, 5, 0, 1'b1);
        tick();
        tick();
        tick();
        n_cmp++; if (px_valid !== 1'b1 || px_x !== CW'(2)) begin n_bad++; $display("FAIL abort_pixel3: got valid=%b x=%0d want 1/2", px_valid, px_x); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", ready); end
        n_cmp++; if (px_valid !== 1'b0) begin n_bad++; $display("FAIL abort_px_valid: got %b want 0", px_valid); end
        n_cmp++; if (done !== 1'b0 || px_x !== CW'(0) || px_y !== CW'(0) || px_color !== KW'(0)) begin
            n_bad++; $display("FAIL abort_outputs: got done=%b x=%0d y=%0d c=%0d want 0/0/0/0", done, px_x, px_y, px_color);
        end
        send_cmd(1'b0, 4, 4, 4, 4, 1'b1);
        collect(1'b0, 50);
        n_cmp++; if (q_x.size() !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", q_x.size()); end
        if (q_x.size() > 0) begin
            n_cmp++;
            if (q_x[0] !== 4 || q_y[0] !== 4 || q_c[0] !== 1) begin
                n_bad++; $display("FAIL single_px: got (%0d,%0d,c%0d) want (4,4,c1)", q_x[0], q_y[0], q_c[0]);
            end
        end
        n_cmp++; if (done_cyc !== start_cyc + 2) begin n_bad++; $display("FAIL single_done_timing: got cycle %0d want %0d", done_cyc, start_cyc + 2); end
        tick();
    endtask

    task automatic test_busy_start();
        int seen;
        px_ready = 1'b0;
        send_cmd(1'b0, 0, 0, 5, 0, 1'b1);
        tick();
        mode     = 1'b1;
        x0 = CW'(10); y0 = CW'(10); x1 = CW'(12); y1 = CW'(12);
        color_in = 1'b0;
        start    = 1'b1;
        tick();
        tick();
        start = 1'b0;
        collect(1'b0, 100);
        n_cmp++; if (q_x.size() !== 6) begin n_bad++; $display("FAIL busy_count: got %0d want 6", q_x.size()); end
        for (int i = 0; i < q_x.size() && i < 6; i++) begin
            n_cmp++;
            if (q_x[i] !== i || q_y[i] !== 0 || q_c[i] !== 1) begin
                n_bad++;
                $display("FAIL busy_px%0d: got (%0d,%0d,c%0d) want (%0d,0,c1)", i, q_x[i], q_y[i], q_c[i], i);
            end
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (px_valid !== 1'b0 || ready !== 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL busy_not_queued: got %0d active cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_hline();
        test_steep();
        test_rect();
        test_backpressure();
        test_clip();
        test_abort();
        test_busy_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
